ws2812b_rx: RTL
===============

# ws2812b_rx

WS2812B single-wire receiver/decoder: samples the NZR serial line produced by the LED shift-register transmitter, measures each high pulse to recover bits, and reassembles them into 24-bit GRB pixel words with a per-frame index. Sits on the Basys 3 fabric beside the transmit chain, either on a loopback of the transmitter's output pin or on an external strip's DOUT. It serves as a self-checking monitor and as the front end of a chain-emulation node.

## Interface
Parameters (cycle counts at the 100 MHz board clock):
- T_MIN_HIGH, 20: shortest legal high pulse; shorter is a glitch
- T_THRESH, 60: high time at or above this decodes as 1, below as 0
- T_MAX_HIGH, 100: longest legal high pulse; longer is an error
- RESET_CYCLES, 5000: low time that marks the latch/reset gap (50 us)

Ports:
- clk  in  1  board clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; low clears all state
- din  in  1  serial WS2812B line, asynchronous to clk
- pixel  out  24  last completed word, first-received bit in [23] (G7..G0, R7..R0, B7..B0)
- pixel_valid  out  1  one-cycle pulse: pixel and pixel_idx are new
- pixel_idx  out  8  position of pixel within the current frame, wraps 255→0
- frame_done  out  1  one-cycle pulse on latch gap after at least one bit
- frame_err  out  1  one-cycle pulse, coincident with frame_done, when bit count is not a multiple of 24
- bit_err  out  1  one-cycle pulse on an illegal high pulse

## Operation
- din passes through a 2-flop synchronizer; a third flop gives rise/fall strobes on the synchronized signal.
- States:
  - SYNC: entered on reset and after any bit_err. Low counter runs while synced din is low and clears on high. Go to ARMED when the count reaches RESET_CYCLES. No frame_done from SYNC.
  - ARMED: wait for a rising strobe, then go to HIGH with the high counter at 1.
  - HIGH: count high cycles, saturating at T_MAX_HIGH+1.
    - Falling strobe with count < T_MIN_HIGH: bit_err, go to SYNC.
    - Otherwise shift bit = (count >= T_THRESH) into the 24-bit shift register, increment bit_cnt (0..23), go to LOW.
    - If count reaches T_MAX_HIGH+1 before a fall: bit_err, go to SYNC. No bit is shifted.
  - LOW: count low cycles.
    - Rising strobe: go to HIGH.
    - Count reaches RESET_CYCLES: frame_done; frame_err if bit_cnt != 0. Discard partial bits, clear bit_cnt and pixel_idx, go to ARMED.
- On the 24th bit: copy the shift register to pixel, pulse pixel_valid, clear bit_cnt.
- pixel_idx holds the index of the presented pixel. It is 0 for the first pixel of a frame and increments on every later pixel_valid.
- On a bit_err, the partial pixel and pixel_idx are discarded. The next pixel after the following gap is index 0.
- Reset values: pixel=0, pixel_idx=0, all pulses 0, state SYNC, counters 0.
- Mid-operation reset asserts all reset values asynchronously. Decoding resumes only after a full RESET_CYCLES low gap following deassertion.

## Timing
- Synchronizer plus edge detect: a din edge appears as a strobe 3 clk edges later. High-time measurement is therefore exact to ±1 cycle.
- pixel_valid is high in the cycle after the synchronized falling strobe of the 24th bit. That is 4 clk edges after the raw din fall.
- frame_done is high in the cycle the low counter equals RESET_CYCLES. That is RESET_CYCLES+3 clk edges after the raw din fall.
- pixel_valid and frame_done can never coincide: a full low gap separates them.
- Back-to-back bits with a 1-cycle low are legal; no minimum low time is enforced.

## Structure
- Package ws2812b_pkg holds:
  - default timing constants: T_MIN_HIGH, T_THRESH, T_MAX_HIGH, RESET_CYCLES, and the transmitter's T0H/T1H/period values;
  - BITS_PER_PIXEL = 24;
  - the state enum.
- Sub-module ws2812b_edge_sync: 2-flop synchronizer plus rise/fall strobes, reused elsewhere for the mode buttons.
- Counter widths are derived with $clog2 of RESET_CYCLES+1 and T_MAX_HIGH+2.

## Test plan
- Reset, then 6000 low cycles, then 24 bits of 0xFF0000 (1 = 80 high/45 low, 0 = 40 high/85 low), then 6000 low → pixel=0xFF0000, pixel_valid once, pixel_idx=0, then frame_done with frame_err=0.
- 96-bit frame 0x00FF00_FF0000_0000FF_FFFFFF → four pixel_valid pulses, idx 0..3 with matching words, one frame_done.
- Frame of 30 bits → one pixel_valid; frame_done and frame_err together; next frame starts at idx 0.
- 10-cycle high pulse mid-pixel → bit_err pulse, no pixel_valid; the following frame is ignored until a 5000-cycle low gap, then decodes correctly.
- din held high 500 cycles → bit_err at high count 101, no frame_done until 5000 low cycles have passed and a new frame is sent.
- reset asserted during the 12th bit → all outputs zero immediately; first frame after release decodes only after a full gap.

Source files
------------

// File: rtl/ws2812b_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ws2812b_pkg                                                  |
// | Description : Shared timing constants and state type for the WS2812B      |
// |               receive path (100 MHz board clock).                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ws2812b_pkg;

  // Receive pulse-classification limits, in clk cycles
  localparam int T_MIN_HIGH   = 20;    // shorter high pulse is a glitch
  localparam int T_THRESH     = 60;    // high time >= this decodes as a 1
  localparam int T_MAX_HIGH   = 100;   // longer high pulse is an error
  localparam int RESET_CYCLES = 5000;  // 50 us latch gap

  // Transmitter nominal timing, kept here so both chains share one source
  localparam int TX_T0H    = 40;
  localparam int TX_T1H    = 80;
  localparam int TX_PERIOD = 125;

  localparam int BITS_PER_PIXEL = 24;

  // Receiver decoder states
  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,  // waiting for a full low gap before trusting the line
    ST_ARMED = 2'd1,  // gap seen, waiting for the first rising edge
    ST_HIGH  = 2'd2,  // measuring a high pulse
    ST_LOW   = 2'd3   // measuring the low time after a bit
  } rxState_t;

endpackage
`default_nettype wire

// File: rtl/ws2812b_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ws2812b_edge_sync                                            |
// | Description : Two-flop synchronizer for an asynchronous input plus        |
// |               single-cycle rise/fall strobes on the synchronized level.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ws2812b_edge_sync (
  input  logic clk,
  input  logic reset,     // asynchronous, active-low
  input  logic asyncIn,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Metastability filter followed by a one-cycle history flop for edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= asyncIn;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign level = r_sync;
  assign rise  = r_sync & ~r_prev;
  assign fall  = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/ws2812b_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ws2812b_rx                                                   |
// | Description : WS2812B single-wire receiver. Measures each high pulse,     |
// |               recovers bits and assembles 24-bit GRB words with a         |
// |               per-frame pixel index; flags frame ends and bad pulses.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ws2812b_rx #(
  parameter int T_MIN_HIGH   = ws2812b_pkg::T_MIN_HIGH,
  parameter int T_THRESH     = ws2812b_pkg::T_THRESH,
  parameter int T_MAX_HIGH   = ws2812b_pkg::T_MAX_HIGH,
  parameter int RESET_CYCLES = ws2812b_pkg::RESET_CYCLES
) (
  input  logic        clk,
  input  logic        reset,        // asynchronous, active-low
  input  logic        din,
  output logic [23:0] pixel,
  output logic        pixel_valid,
  output logic [7:0]  pixel_idx,
  output logic        frame_done,
  output logic        frame_err,
  output logic        bit_err
);

  import ws2812b_pkg::*;

  localparam int LOW_W  = $clog2(RESET_CYCLES + 1);
  localparam int HIGH_W = $clog2(T_MAX_HIGH + 2);
  localparam int BIT_W  = $clog2(BITS_PER_PIXEL);

  localparam logic [LOW_W-1:0]  c_LOW_ONE   = LOW_W'(1);
  localparam logic [LOW_W-1:0]  c_LOW_LIMIT = LOW_W'(RESET_CYCLES);
  localparam logic [HIGH_W-1:0] c_HIGH_ONE  = HIGH_W'(1);
  localparam logic [HIGH_W-1:0] c_HIGH_MIN  = HIGH_W'(T_MIN_HIGH);
  localparam logic [HIGH_W-1:0] c_HIGH_THR  = HIGH_W'(T_THRESH);
  localparam logic [HIGH_W-1:0] c_HIGH_OVER = HIGH_W'(T_MAX_HIGH + 1);
  localparam logic [BIT_W-1:0]  c_BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]  c_LAST_BIT  = BIT_W'(BITS_PER_PIXEL - 1);

  // Synchronized line and its edge strobes
  logic w_level;
  logic w_rise;
  logic w_fall;

  ws2812b_edge_sync u_edgeSync (
    .clk     (clk),
    .reset   (reset),
    .asyncIn (din),
    .level   (w_level),
    .rise    (w_rise),
    .fall    (w_fall)
  );

  rxState_t            r_state;
  logic [LOW_W-1:0]    r_lowCnt;
  logic [HIGH_W-1:0]   r_highCnt;
  logic [BIT_W-1:0]    r_bitCnt;
  logic [23:0]         r_shift;
  logic                r_havePix;   // a pixel has already been presented this frame

  logic [LOW_W-1:0]    w_lowNext;
  logic [HIGH_W-1:0]   w_highNext;
  logic                w_bit;
  logic                w_tooShort;
  logic [23:0]         w_word;

  assign w_lowNext  = r_lowCnt + c_LOW_ONE;
  assign w_highNext = r_highCnt + c_HIGH_ONE;
  assign w_bit      = (r_highCnt >= c_HIGH_THR);
  assign w_tooShort = (r_highCnt < c_HIGH_MIN);
  assign w_word     = {r_shift[22:0], w_bit};

  // Decoder state machine with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_SYNC;
      r_lowCnt    <= '0;
      r_highCnt   <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_havePix   <= 1'b0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      pixel_idx   <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      bit_err     <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      bit_err     <= 1'b0;

      case (r_state)
        ST_SYNC: begin
          // Only a complete low gap makes the line trustworthy again
          if (w_level) begin
            r_lowCnt <= '0;
          end else if (w_lowNext == c_LOW_LIMIT) begin
            r_lowCnt <= '0;
            r_state  <= ST_ARMED;
          end else begin
            r_lowCnt <= w_lowNext;
          end
        end

        ST_ARMED: begin
          if (w_rise) begin
            r_highCnt <= c_HIGH_ONE;
            r_state   <= ST_HIGH;
          end
        end

        ST_HIGH: begin
          if (w_fall) begin
            if (w_tooShort) begin
              // Glitch: drop the partial pixel and the frame position
              bit_err   <= 1'b1;
              r_bitCnt  <= '0;
              r_havePix <= 1'b0;
              pixel_idx <= '0;
              r_lowCnt  <= c_LOW_ONE;   // the strobe cycle is already low
              r_state   <= ST_SYNC;
            end else begin
              r_shift  <= w_word;
              r_lowCnt <= c_LOW_ONE;
              r_state  <= ST_LOW;
              if (r_bitCnt == c_LAST_BIT) begin
                pixel       <= w_word;
                pixel_valid <= 1'b1;
                r_bitCnt    <= '0;
                r_havePix   <= 1'b1;
                pixel_idx   <= r_havePix ? (pixel_idx + 8'd1) : 8'd0;
              end else begin
                r_bitCnt <= r_bitCnt + c_BIT_ONE;
              end
            end
          end else if (w_highNext == c_HIGH_OVER) begin
            // Stuck-high line: abort without shifting a bit
            r_highCnt <= w_highNext;
            bit_err   <= 1'b1;
            r_bitCnt  <= '0;
            r_havePix <= 1'b0;
            pixel_idx <= '0;
            r_lowCnt  <= '0;
            r_state   <= ST_SYNC;
          end else begin
            r_highCnt <= w_highNext;
          end
        end

        ST_LOW: begin
          if (w_rise) begin
            r_highCnt <= c_HIGH_ONE;
            r_state   <= ST_HIGH;
          end else if (w_lowNext == c_LOW_LIMIT) begin
            // Latch gap closes the frame; any leftover bits are a short pixel
            frame_done <= 1'b1;
            frame_err  <= (r_bitCnt != '0);
            r_bitCnt   <= '0;
            r_havePix  <= 1'b0;
            pixel_idx  <= '0;
            r_lowCnt   <= '0;
            r_state    <= ST_ARMED;
          end else begin
            r_lowCnt <= w_lowNext;
          end
        end

        default: begin
          r_state <= ST_SYNC;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
